// File: rtl/sort_pkg.sv
// Shared types and sizing for the 32-element unsigned byte sorter.
package sort_pkg;

    localparam int N      = 32;
    localparam int W      = 8;
    localparam int LOG2N  = 5;
    localparam int STAGES = LOG2N * (LOG2N + 1) / 2;

    typedef logic [W-1:0] elem_t;
    typedef elem_t        vec_t [N];

endpackage

// File: rtl/cmp_swap_u8.sv
// Compare-exchange cell: orders one unsigned byte pair up or down.
module cmp_swap_u8 (
    input  logic       asc,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] lo,
    output logic [7:0] hi
);

    logic swap;

    // Equal values never swap, so ties pass straight through.
    assign swap = asc ? (a > b) : (a < b);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/sort_32_u8.sv
// Fully pipelined 32-input bitonic sorter, one register stage per network column.
module sort_32_u8
    import sort_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vld_in,
    input  logic [7:0] din_0,  input  logic [7:0] din_1,  input  logic [7:0] din_2,  input  logic [7:0] din_3,
    input  logic [7:0] din_4,  input  logic [7:0] din_5,  input  logic [7:0] din_6,  input  logic [7:0] din_7,
    input  logic [7:0] din_8,  input  logic [7:0] din_9,  input  logic [7:0] din_10, input  logic [7:0] din_11,
    input  logic [7:0] din_12, input  logic [7:0] din_13, input  logic [7:0] din_14, input  logic [7:0] din_15,
    input  logic [7:0] din_16, input  logic [7:0] din_17, input  logic [7:0] din_18, input  logic [7:0] din_19,
    input  logic [7:0] din_20, input  logic [7:0] din_21, input  logic [7:0] din_22, input  logic [7:0] din_23,
    input  logic [7:0] din_24, input  logic [7:0] din_25, input  logic [7:0] din_26, input  logic [7:0] din_27,
    input  logic [7:0] din_28, input  logic [7:0] din_29, input  logic [7:0] din_30, input  logic [7:0] din_31,
    output logic       vld_out,
    output logic [7:0] dout_0,  output logic [7:0] dout_1,  output logic [7:0] dout_2,  output logic [7:0] dout_3,
    output logic [7:0] dout_4,  output logic [7:0] dout_5,  output logic [7:0] dout_6,  output logic [7:0] dout_7,
    output logic [7:0] dout_8,  output logic [7:0] dout_9,  output logic [7:0] dout_10, output logic [7:0] dout_11,
    output logic [7:0] dout_12, output logic [7:0] dout_13, output logic [7:0] dout_14, output logic [7:0] dout_15,
    output logic [7:0] dout_16, output logic [7:0] dout_17, output logic [7:0] dout_18, output logic [7:0] dout_19,
    output logic [7:0] dout_20, output logic [7:0] dout_21, output logic [7:0] dout_22, output logic [7:0] dout_23,
    output logic [7:0] dout_24, output logic [7:0] dout_25, output logic [7:0] dout_26, output logic [7:0] dout_27,
    output logic [7:0] dout_28, output logic [7:0] dout_29, output logic [7:0] dout_30, output logic [7:0] dout_31
);

    vec_t              din_vec;
    vec_t              col_in  [STAGES];
    vec_t              col_out [STAGES];
    vec_t              stage_q [STAGES];
    logic [STAGES-1:0] vld_q;

    assign din_vec[0]  = din_0;   assign din_vec[1]  = din_1;   assign din_vec[2]  = din_2;   assign din_vec[3]  = din_3;
    assign din_vec[4]  = din_4;   assign din_vec[5]  = din_5;   assign din_vec[6]  = din_6;   assign din_vec[7]  = din_7;
    assign din_vec[8]  = din_8;   assign din_vec[9]  = din_9;   assign din_vec[10] = din_10;  assign din_vec[11] = din_11;
    assign din_vec[12] = din_12;  assign din_vec[13] = din_13;  assign din_vec[14] = din_14;  assign din_vec[15] = din_15;
    assign din_vec[16] = din_16;  assign din_vec[17] = din_17;  assign din_vec[18] = din_18;  assign din_vec[19] = din_19;
    assign din_vec[20] = din_20;  assign din_vec[21] = din_21;  assign din_vec[22] = din_22;  assign din_vec[23] = din_23;
    assign din_vec[24] = din_24;  assign din_vec[25] = din_25;  assign din_vec[26] = din_26;  assign din_vec[27] = din_27;
    assign din_vec[28] = din_28;  assign din_vec[29] = din_29;  assign din_vec[30] = din_30;  assign din_vec[31] = din_31;

    // Phase p merges bitonic runs of size k = 2**p; step q compares at distance j = 2**q.
    for (genvar p = 1; p <= LOG2N; p++) begin : g_phase
        for (genvar q = p - 1; q >= 0; q--) begin : g_step
            localparam int S = p * (p - 1) / 2 + (p - 1 - q);

            if (S == 0) begin : g_first
                assign col_in[S] = din_vec;
            end else begin : g_next
                assign col_in[S] = stage_q[S-1];
            end

            for (genvar c = 0; c < N / 2; c++) begin : g_cell
                // Insert a zero at bit q of the cell number to get the lower index of the pair.
                localparam int   I   = ((c >> q) << (q + 1)) | (c & ((1 << q) - 1));
                localparam int   J   = I | (1 << q);
                localparam logic ASC = (((I >> p) & 1) == 0);

                cmp_swap_u8 u_cmp (
                    .asc (ASC),
                    .a   (col_in[S][I]),
                    .b   (col_in[S][J]),
                    .lo  (col_out[S][I]),
                    .hi  (col_out[S][J])
                );
            end
        end
    end

    // NOTE: the data pipeline is reset along with the valid bits so dout reads zero
    // during and after reset; sequential state is written only with non-blocking <=.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                for (int e = 0; e < N; e++) begin
                    stage_q[s][e] <= '0;
                end
            end
            vld_q <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= col_out[s];
            end
            vld_q <= {vld_q[STAGES-2:0], vld_in};
        end
    end

    assign vld_out = vld_q[STAGES-1];

    assign dout_0  = stage_q[STAGES-1][0];   assign dout_1  = stage_q[STAGES-1][1];
    assign dout_2  = stage_q[STAGES-1][2];   assign dout_3  = stage_q[STAGES-1][3];
    assign dout_4  = stage_q[STAGES-1][4];   assign dout_5  = stage_q[STAGES-1][5];
    assign dout_6  = stage_q[STAGES-1][6];   assign dout_7  = stage_q[STAGES-1][7];
    assign dout_8  = stage_q[STAGES-1][8];   assign dout_9  = stage_q[STAGES-1][9];
    assign dout_10 = stage_q[STAGES-1][10];  assign dout_11 = stage_q[STAGES-1][11];
    assign dout_12 = stage_q[STAGES-1][12];  assign dout_13 = stage_q[STAGES-1][13];
    assign dout_14 = stage_q[STAGES-1][14];  assign dout_15 = stage_q[STAGES-1][15];
    assign dout_16 = stage_q[STAGES-1][16];  assign dout_17 = stage_q[STAGES-1][17];
    assign dout_18 = stage_q[STAGES-1][18];  assign dout_19 = stage_q[STAGES-1][19];
    assign dout_20 = stage_q[STAGES-1][20];  assign dout_21 = stage_q[STAGES-1][21];
    assign dout_22 = stage_q[STAGES-1][22];  assign dout_23 = stage_q[STAGES-1][23];
    assign dout_24 = stage_q[STAGES-1][24];  assign dout_25 = stage_q[STAGES-1][25];
    assign dout_26 = stage_q[STAGES-1][26];  assign dout_27 = stage_q[STAGES-1][27];
    assign dout_28 = stage_q[STAGES-1][28];  assign dout_29 = stage_q[STAGES-1][29];
    assign dout_30 = stage_q[STAGES-1][30];  assign dout_31 = stage_q[STAGES-1][31];

endmodule

// File: tb/tb_sort_32_u8.sv
// Self-checking bench for sort_32_u8 against a queue-sort reference with a due-edge scoreboard.
module tb_sort_32_u8;

    typedef struct {
        int           due;
        logic [255:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vld_in = 1'b0;
    logic [7:0] din  [32];
    logic [7:0] dout [32];
    logic       vld_out;

    int   n_checks = 0;
    int   n_errors = 0;
    int   edge_n   = 0;
    exp_t exp_q [$];

    always #5 clk = ~clk;

    sort_32_u8 dut (
        .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .vld_out(vld_out),
        .din_0(din[0]),   .din_1(din[1]),   .din_2(din[2]),   .din_3(din[3]),
        .din_4(din[4]),   .din_5(din[5]),   .din_6(din[6]),   .din_7(din[7]),
        .din_8(din[8]),   .din_9(din[9]),   .din_10(din[10]), .din_11(din[11]),
        .din_12(din[12]), .din_13(din[13]), .din_14(din[14]), .din_15(din[15]),
        .din_16(din[16]), .din_17(din[17]), .din_18(din[18]), .din_19(din[19]),
        .din_20(din[20]), .din_21(din[21]), .din_22(din[22]), .din_23(din[23]),
        .din_24(din[24]), .din_25(din[25]), .din_26(din[26]), .din_27(din[27]),
        .din_28(din[28]), .din_29(din[29]), .din_30(din[30]), .din_31(din[31]),
        .dout_0(dout[0]),   .dout_1(dout[1]),   .dout_2(dout[2]),   .dout_3(dout[3]),
        .dout_4(dout[4]),   .dout_5(dout[5]),   .dout_6(dout[6]),   .dout_7(dout[7]),
        .dout_8(dout[8]),   .dout_9(dout[9]),   .dout_10(dout[10]), .dout_11(dout[11]),
        .dout_12(dout[12]), .dout_13(dout[13]), .dout_14(dout[14]), .dout_15(dout[15]),
        .dout_16(dout[16]), .dout_17(dout[17]), .dout_18(dout[18]), .dout_19(dout[19]),
        .dout_20(dout[20]), .dout_21(dout[21]), .dout_22(dout[22]), .dout_23(dout[23]),
        .dout_24(dout[24]), .dout_25(dout[25]), .dout_26(dout[26]), .dout_27(dout[27]),
        .dout_28(dout[28]), .dout_29(dout[29]), .dout_30(dout[30]), .dout_31(dout[31])
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] pack_out();
        logic [255:0] v;
        for (int i = 0; i < 32; i++) v[8*i +: 8] = dout[i];
        return v;
    endfunction

    // Reference: the ascending multiset of the current inputs, element i at bits [8i+:8].
    function automatic logic [255:0] sorted_in();
        int           q [$];
        logic [255:0] v;
        for (int i = 0; i < 32; i++) q.push_back(int'(din[i]));
        q.sort();
        for (int i = 0; i < 32; i++) v[8*i +: 8] = 8'(q[i]);
        return v;
    endfunction

    function automatic logic [255:0] pack_list(input int vals [32]);
        logic [255:0] v;
        for (int i = 0; i < 32; i++) v[8*i +: 8] = 8'(vals[i]);
        return v;
    endfunction

    // One clock: record what the edge samples, then check outputs 1 time unit later.
    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        if (rst_n && vld_in) begin
            e.due  = edge_n + 14;
            e.data = sorted_in();
            exp_q.push_back(e);
        end
        #1;
        if (!rst_n) begin
            check({tag, "_rst_vld"}, {255'd0, vld_out}, 256'd0);
            check({tag, "_rst_dout"}, pack_out(), 256'd0);
        end else if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
            check({tag, "_vld"}, {255'd0, vld_out}, 256'd1);
            check({tag, "_data"}, pack_out(), exp_q[0].data);
            void'(exp_q.pop_front());
        end else begin
            check({tag, "_idle"}, {255'd0, vld_out}, 256'd0);
        end
        edge_n++;
    endtask

    task automatic drive_rand(input logic v);
        vld_in = v;
        for (int i = 0; i < 32; i++) din[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic drain(input string tag);
        vld_in = 1'b0;
        for (int c = 0; c < 16; c++) tick(tag);
    endtask

    int vec_a  [32] = '{31,29,27,25,23,21,19,17,15,13,11,9,7,5,3,1,2,2,4,4,4,4,8,16,8,16,32,32,0,10,20,30};
    int sort_a [32] = '{0,1,2,2,3,4,4,4,4,5,7,8,8,9,10,11,13,15,16,16,17,19,20,21,23,25,27,29,30,31,32,32};
    int rev_exp[32];

    initial begin
        for (int i = 0; i < 32; i++) din[i] = 8'd0;

        // Reset held with live-looking traffic on the inputs.
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_rand(1'b1);
            tick("reset");
        end
        #2;
        rst_n  = 1'b1;
        vld_in = 1'b0;
        tick("post_reset");

        // Directed vector with duplicates, one-cycle pulse; output also checked against the literal.
        for (int i = 0; i < 32; i++) din[i] = 8'(vec_a[i]);
        vld_in = 1'b1;
        tick("vec_a_in");
        drive_rand(1'b0);
        for (int c = 0; c < 13; c++) tick("vec_a_wait");
        tick("vec_a_out");
        check("vec_a_literal", pack_out(), pack_list(sort_a));
        tick("vec_a_after");

        // Reverse order.
        for (int i = 0; i < 32; i++) begin
            din[i]     = 8'(31 - i);
            rev_exp[i] = i;
        end
        vld_in = 1'b1;
        tick("reverse_in");
        vld_in = 1'b0;
        for (int c = 0; c < 14; c++) tick("reverse");
        check("reverse_literal", pack_out(), pack_list(rev_exp));

        // Extremes, then all-equal, back to back.
        for (int i = 0; i < 32; i++) din[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
        vld_in = 1'b1;
        tick("extreme_in");
        for (int i = 0; i < 32; i++) din[i] = 8'h7F;
        tick("equal_in");
        vld_in = 1'b0;
        for (int c = 0; c < 13; c++) tick("extreme");
        check("extreme_literal", pack_out(), {{16{8'hFF}}, {16{8'h00}}});
        tick("equal");
        check("equal_literal", pack_out(), {32{8'h7F}});
        drain("edge_drain");

        // Streaming: 100 back-to-back, 3-cycle gap, 5 more.
        for (int c = 0; c < 100; c++) begin
            drive_rand(1'b1);
            tick("stream_a");
        end
        for (int c = 0; c < 3; c++) begin
            drive_rand(1'b0);
            tick("stream_gap");
        end
        for (int c = 0; c < 5; c++) begin
            drive_rand(1'b1);
            tick("stream_b");
        end
        drain("stream_drain");
        check("scoreboard_empty", 256'(exp_q.size()), 256'd0);

        // Reset mid-stream: everything in flight is discarded.
        for (int c = 0; c < 20; c++) begin
            drive_rand(1'b1);
            tick("pre_abort");
        end
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_async_vld", {255'd0, vld_out}, 256'd0);
        tick("abort_hold");
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            drive_rand(1'b0);
            tick("abort_quiet");
        end
        for (int c = 0; c < 5; c++) begin
            drive_rand(1'b1);
            tick("restart");
        end
        drain("restart_drain");
        check("final_scoreboard_empty", 256'(exp_q.size()), 256'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sort_32_u8.md
Name: sort_32_u8

Overview:
- Fully pipelined hardware sorter: 32 unsigned 8-bit values in, the same 32 values out in ascending order.
- Built as a bitonic sorting network, one register stage per network column.
- One vector is accepted per clock with no backpressure.
- Sits as a datapath block; upstream qualifies each input vector with vld_in, downstream consumes results on vld_out.

Parameters:
- None exposed. Fixed localparams:
  - N = 32: element count.
  - W = 8: element width.
  - STAGES = 15: bitonic columns, equal to log2(N)*(log2(N)+1)/2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- vld_in  input  1  din_0..din_31 carry a valid vector this cycle.
- din_0 .. din_31  input  8 each  unsigned input elements; index order carries no meaning.
- vld_out  output  1  dout_0..dout_31 carry a sorted result this cycle.
- dout_0 .. dout_31  output  8 each  sorted result; dout_0 is the minimum, dout_31 the maximum.

Behaviour:
- Reset:
  - rst_n low asynchronously clears every pipeline data register and every valid bit.
  - While and after reset: vld_out=0 and all dout_*=0.
  - Reset mid-operation discards all in-flight vectors; no partial result is ever flagged valid.
- Network: standard 32-input bitonic sort.
  - Phases: merge sizes k = 2, 4, 8, 16, 32.
  - Within each phase, sub-steps j = k/2 down to 1.
  - Each column has 16 compare-exchange cells. Cell pair is (i, i^j) for i with bit j clear.
  - Cell direction: ascending if bit k of i is 0, else descending; at k=32 all cells are ascending.
- Compare-exchange:
  - Unsigned 8-bit compare.
  - Ascending cell: lower index gets min(a,b), higher index gets max(a,b).
  - Ties pass both values unchanged; equal values are indistinguishable, so stability does not matter.
- Pipelining: each of the 15 columns is followed by a register, and outputs are driven directly from column 15's register.
- Latency:
  - A vector sampled on rising edge E (vld_in=1) appears on dout with vld_out=1 after edge E+14.
  - It holds until edge E+15. Latency is 15 clocks, counting the sampling edge as the first.
- Throughput: one vector per clock.
  - Back-to-back vld_in cycles produce back-to-back vld_out cycles in the same order.
  - Gaps are preserved exactly.
- Valid path: a 15-deep shift register of vld_in, reset to 0.
- Data registers:
  - Advance every cycle regardless of vld_in; no enable.
  - dout contents while vld_out=0 are don't-care and are not checked.
- Inputs are sampled only on the edge; din may change freely between edges.
- Boundaries:
  - All-equal inputs come out unchanged.
  - Values 0 and 255 sort correctly; there is no signed interpretation.
  - Duplicate values are all retained, and the output is a permutation of the input.

Decomposition:
- Package sort_pkg holds:
  - localparams N=32, W=8, LOG2N=5, STAGES=15;
  - typedef elem_t as an 8-bit unsigned logic vector;
  - typedef vec_t as an array of N elem_t.
- One natural sub-module: cmp_swap_u8.
  - Combinational; inputs a, b and an ascending/descending select; outputs lo, hi.
  - Instantiated 16 per column via generate loops.
- Top module flattens the 32 named ports to/from vec_t.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks with random din and vld_in=1 -> vld_out=0 and all dout=0 throughout.
- Single vector, one-cycle vld_in pulse:
  - din_0..31 = 31,29,27,25,23,21,19,17,15,13,11,9,7,5,3,1,2,2,4,4,4,4,8,16,8,16,32,32,0,10,20,30.
  - Required result after exactly 15 clocks: vld_out high for exactly one cycle with dout_0..31 = 0,1,2,2,3,4,4,4,4,5,7,8,8,9,10,11,13,15,16,16,17,19,20,21,23,25,27,29,30,31,32,32.
- Reverse input: din_i = 31-i -> dout_i = i.
- Extremes: alternating 255/0 -> dout_0..15 = 0 and dout_16..31 = 255.
- All-equal: every din = 0x7F -> every dout = 0x7F.
- Streaming:
  - 100 consecutive random vectors with vld_in=1, then a 3-cycle gap, then 5 more.
  - Each output equals a software sort of its input, 15 clocks later, in order, with the gap reproduced on vld_out.
  - Also assert rst_n mid-stream -> vld_out drops immediately and stays 0 until new valid inputs propagate.
